// File: rtl/div_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : div_pkg
// Brief    : Shared FSM encoding and constants for the iterative divider.
// Revision : 1.0
//------------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

  // Replicated across the full width to form the divide-by-zero quotient.
  localparam logic c_DBZ_QUOT_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : div_gen_if
// Brief     : Request/result handshake bundle for div_gen.
// Revision  : 1.0
//------------------------------------------------------------------------------
interface div_gen_if #(
  parameter int WIDTH = 32
);
  import div_pkg::*;

  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             annul_i;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             dbz_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output signed_i, dividend_i, divisor_i, in_valid_i, annul_i, out_ready_i,
    input  in_ready_o, quot_o, rem_o, dbz_o, out_valid_o
  );

  modport slave (
    input  signed_i, dividend_i, divisor_i, in_valid_i, annul_i, out_ready_i,
    output in_ready_o, quot_o, rem_o, dbz_o, out_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_step
// Brief    : One combinational restoring-division step.
// Revision : 1.0
//------------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the trial MSB is a reliable borrow flag.
  always_comb begin
    w_shifted = {part_rem, next_bit};
    w_trial   = w_shifted - {1'b0, divisor};
    quot_bit  = ~w_trial[WIDTH];
    new_rem   = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/div_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_gen
// Brief    : Iterative signed/unsigned restoring divider with annul support.
// Revision : 1.0
//------------------------------------------------------------------------------
module div_gen
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic      clk,
  input  logic      rst,
  div_gen_if.slave  bus
);

  localparam int                 c_STEPS = WIDTH / STEP_BITS;
  localparam int                 c_CNT_W = $clog2(c_STEPS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_STEPS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  div_state_t         r_state;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_signed;
  logic               r_dvd_neg;
  logic               r_sign_xor;
  logic               r_out_valid;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_quot_out;
  logic [WIDTH-1:0]   r_rem_out;

  logic [WIDTH-1:0]   w_rem_chain [STEP_BITS+1];
  logic [STEP_BITS-1:0] w_qbits;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;

  always_comb begin
    w_dvd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
    w_dvs_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? ('0 - bus.dividend_i) : bus.dividend_i;
    w_dvs_mag = w_dvs_neg ? ('0 - bus.divisor_i)  : bus.divisor_i;
  end

  // r_quot starts as the dividend magnitude; its MSBs feed the step chain and
  // quotient bits shift in at the bottom.
  assign w_rem_chain[0] = r_rem;

  for (genvar k = 0; k < STEP_BITS; k++) begin : g_step
    div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .part_rem (w_rem_chain[k]),
      .divisor  (r_divisor),
      .next_bit (r_quot[WIDTH-1-k]),
      .new_rem  (w_rem_chain[k+1]),
      .quot_bit (w_qbits[STEP_BITS-1-k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_sign_xor  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_quot_out  <= '0;
      r_rem_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid_i && !bus.annul_i) begin
            if (bus.divisor_i == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_dbz       <= 1'b1;
              r_quot_out  <= {WIDTH{c_DBZ_QUOT_BIT}};
              r_rem_out   <= bus.dividend_i;
            end else begin
              r_state    <= ST_BUSY;
              r_rem      <= '0;
              r_quot     <= w_dvd_mag;
              r_divisor  <= w_dvs_mag;
              r_signed   <= bus.signed_i;
              r_dvd_neg  <= w_dvd_neg;
              r_sign_xor <= w_dvd_neg ^ w_dvs_neg;
              r_cnt      <= '0;
            end
          end
        end

        ST_BUSY: begin
          if (bus.annul_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_rem  <= w_rem_chain[STEP_BITS];
            r_quot <= {r_quot[WIDTH-STEP_BITS-1:0], w_qbits};
            r_cnt  <= r_cnt + c_ONE;
            if (r_cnt == c_LAST) begin
              r_state <= ST_FIXUP;
            end
          end
        end

        ST_FIXUP: begin
          if (bus.annul_i) begin
            r_state <= ST_IDLE;
          end else begin
            // Remainder sign follows the dividend; most-negative / -1 wraps.
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_dbz       <= 1'b0;
            r_quot_out  <= (r_signed && r_sign_xor) ? ('0 - r_quot) : r_quot;
            r_rem_out   <= (r_signed && r_dvd_neg)  ? ('0 - r_rem)  : r_rem;
          end
        end

        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_quot_out  <= '0;
            r_rem_out   <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == ST_IDLE);
  assign bus.out_valid_o = r_out_valid;
  assign bus.dbz_o       = r_dbz;
  assign bus.quot_o      = r_quot_out;
  assign bus.rem_o       = r_rem_out;

endmodule
`default_nettype wire

// File: tb/tb_div_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_div_gen
// Brief    : Directed and randomized checks for div_gen at 32/1 and 16/2.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_div_gen;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_gen_if #(.WIDTH(32)) b32 ();
  div_gen_if #(.WIDTH(16)) b16 ();

  div_gen #(.WIDTH(32), .STEP_BITS(1)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  div_gen #(.WIDTH(16), .STEP_BITS(2)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic valid_of(int sel);
    return (sel == 0) ? b32.out_valid_o : b16.out_valid_o;
  endfunction

  function automatic logic ready_of(int sel);
    return (sel == 0) ? b32.in_ready_o : b16.in_ready_o;
  endfunction

  // {in_ready, out_valid, dbz, quot, rem}
  function automatic logic [66:0] outs(int sel);
    if (sel == 0)
      return {b32.in_ready_o, b32.out_valid_o, b32.dbz_o, b32.quot_o, b32.rem_o};
    return {b16.in_ready_o, b16.out_valid_o, b16.dbz_o, 16'h0, b16.quot_o, 16'h0, b16.rem_o};
  endfunction

  task automatic drive(input int sel, input bit v, input bit sgn,
                       input logic [31:0] a, input logic [31:0] d, input bit an);
    b32.signed_i   = sgn;
    b32.dividend_i = a;
    b32.divisor_i  = d;
    b32.in_valid_i = (sel == 0) && v;
    b32.annul_i    = (sel == 0) && an;
    b16.signed_i   = sgn;
    b16.dividend_i = a[15:0];
    b16.divisor_i  = d[15:0];
    b16.in_valid_i = (sel == 1) && v;
    b16.annul_i    = (sel == 1) && an;
  endtask

  task automatic set_out_ready(input int sel, input bit v);
    if (sel == 0) b32.out_ready_i = v;
    else          b16.out_ready_i = v;
  endtask

  // Reference: plain integer division; SV truncates toward zero and the
  // remainder takes the dividend's sign.
  function automatic logic [64:0] ref_div(int w, bit sgn, logic [31:0] a, logic [31:0] d);
    longint m, sa, sd, q, r;
    m  = (longint'(1) << w) - 1;
    sa = longint'({32'h0, a}) & m;
    sd = longint'({32'h0, d}) & m;
    if (sd == 0) return {1'b1, m[31:0], sa[31:0]};
    if (sgn && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && sd[w-1]) sd = sd - (longint'(1) << w);
    q = (sa / sd) & m;
    r = (sa % sd) & m;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: v = '0;
      1: v = '1;
      2: v = 32'h1 << (w - 1);
      3: v = v >> $urandom_range(1, w - 1);
      4: v = 32'(1 + $urandom_range(0, 6));
      default: ;
    endcase
    if (w == 16) v[31:16] = '0;
    return v;
  endfunction

  task automatic run_op(input int sel, input bit sgn, input logic [31:0] a, input logic [31:0] d,
                        input logic [64:0] exp, input int hold, input string tag);
    int          lat;
    int          exp_lat;
    logic [31:0] dm;
    dm      = (sel == 1) ? (d & 32'h0000_FFFF) : d;
    exp_lat = (dm == 0) ? 1 : ((sel == 1) ? 10 : 34);
    lat = 0;
    while (!ready_of(sel) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    drive(sel, 1'b1, sgn, a, d, 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b0, sgn, a, d, 1'b0);
    lat = 1;
    if (!valid_of(sel)) check({tag, "/busy_zero"}, 96'(outs(sel)), 96'(0));
    while (!valid_of(sel) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "/latency"}, 96'(lat), 96'(exp_lat));
    check({tag, "/result"}, 96'(outs(sel)), 96'({1'b0, 1'b1, exp}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold"}, 96'(outs(sel)), 96'({1'b0, 1'b1, exp}));
    end
    set_out_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_out_ready(sel, 1'b0);
    check({tag, "/release"}, 96'(outs(sel)), 96'({1'b1, 66'b0}));
  endtask

  task automatic watch_quiet(input int sel, input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid_of(sel) || !ready_of(sel)) seen = 1'b1;
    end
    check({tag, "/quiet"}, 96'(seen), 96'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit          sgn;
    int          sel;
    int          w;
    int          lat;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    b32.out_ready_i = 1'b0;
    b16.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", 96'(outs(0)), 96'({1'b1, 66'b0}));
    check("reset16", 96'(outs(1)), 96'({1'b1, 66'b0}));
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit, one bit per cycle
    run_op(0, 1'b0, 32'd100, 32'd7, {1'b0, 32'd14, 32'd2}, 0, "u32_100_7");
    run_op(0, 1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF}, 0, "s32_m7_2");
    run_op(0, 1'b1, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD, 32'd1}, 0, "s32_7_m2");
    run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h8000_0000, 32'h0}, 0, "s32_min_m1");
    run_op(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000}, 0, "u32_big");
    run_op(0, 1'b0, 32'h1234, 32'h0, {1'b1, 32'hFFFF_FFFF, 32'h1234}, 0, "dbz32");
    run_op(0, 1'b1, 32'hFFFF_FFF0, 32'h0, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0}, 0, "dbz32_neg");
    run_op(0, 1'b0, 32'd100, 32'd7, {1'b0, 32'd14, 32'd2}, 5, "backpressure");

    // request with annul in the same cycle is dropped
    drive(0, 1'b1, 1'b0, 32'd5, 32'd1, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd5, 32'd1, 1'b0);
    check("drop/idle", 96'(outs(0)), 96'({1'b1, 66'b0}));
    watch_quiet(0, 40, "drop");

    // annul at BUSY cycle 10
    drive(0, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("annul/busy", 96'(outs(0)), 96'(0));
    b32.annul_i = 1'b1;
    @(posedge clk); #1;
    b32.annul_i = 1'b0;
    check("annul/idle", 96'(outs(0)), 96'({1'b1, 66'b0}));
    watch_quiet(0, 40, "annul");
    run_op(0, 1'b1, 32'hFFFF_FF9C, 32'd9, {1'b0, 32'hFFFF_FFF5, 32'hFFFF_FFFF}, 0, "after_annul");

    // reset mid-BUSY
    drive(0, 1'b1, 1'b0, 32'd77, 32'd5, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd77, 32'd5, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 96'(outs(0)), 96'({1'b1, 66'b0}));
    watch_quiet(0, 40, "rst_busy");

    // reset while holding a result in DONE
    drive(0, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd9, 32'd0, 1'b0);
    check("rst_done/pre", 96'(outs(0)), 96'({1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd9}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done", 96'(outs(0)), 96'({1'b1, 66'b0}));

    // 16-bit, two bits per cycle
    run_op(1, 1'b0, 32'd100, 32'd7, {1'b0, 32'd14, 32'd2}, 0, "u16_100_7");
    run_op(1, 1'b1, 32'hFFF9, 32'd2, {1'b0, 32'hFFFD, 32'hFFFF}, 0, "s16_m7_2");
    run_op(1, 1'b1, 32'd7, 32'hFFFE, {1'b0, 32'hFFFD, 32'd1}, 0, "s16_7_m2");
    run_op(1, 1'b1, 32'h8000, 32'hFFFF, {1'b0, 32'h8000, 32'h0}, 0, "s16_min_m1");
    run_op(1, 1'b0, 32'h1234, 32'h0, {1'b1, 32'hFFFF, 32'h1234}, 3, "dbz16");

    // randomized against the reference model
    for (int i = 0; i < 3500; i++) begin
      sel = (i < 3000) ? 1 : 0;
      w   = (sel == 1) ? 16 : 32;
      a   = pick(w);
      d   = pick(w);
      sgn = 1'($urandom_range(0, 1));
      run_op(sel, sgn, a, d, ref_div(w, sgn, a, d), 0, (sel == 1) ? "rnd16" : "rnd32");
    end

    lat = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
